fp_norm_seq: RTL and testbench

FP_NORM_SEQ -- requirements
Module: fp_norm_seq

---
 rtl/fp_norm_seq.sv | 170 +++++++++++++++++
 tb/tb_fp_norm_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_seq.sv
// rtl/fp_norm_seq.sv - sequential byte-serial left normalizer for unnormalized mantissas
//
// Accepts an unnormalized mantissa/exponent pair and scans it one byte per cycle
// from the MSB with a single 8-bit leading-zero counter. It then left-shifts the
// mantissa so its MSB is 1 and lowers the exponent by the shift amount. The
// exponent saturates at 0 and raises o_uflow when it would go negative.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid / o_ready    operand handshake (o_ready only in IDLE)
//   i_mant, i_exp        unnormalized mantissa and its biased exponent
//   o_valid / i_ready    result handshake (o_valid only in DONE)
//   o_mant, o_exp        normalized mantissa and adjusted exponent
//   o_lzc                total leading zeros (0..W)
//   o_zero, o_uflow      all-zero input flag, exponent underflow flag
module fp_norm_seq #(
    parameter int W     = 48,
    parameter int EXP_W = 10,
    parameter int LZ_W  = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_mant,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_mant,
    output logic [EXP_W-1:0] o_exp,
    output logic [LZ_W-1:0]  o_lzc,
    output logic             o_zero,
    output logic             o_uflow
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

    localparam int NB = W / 8;
    localparam logic [2:0] K_LAST = 3'(NB - 1);
    // Common width for comparing the shift amount against the exponent.
    localparam int CMP_W = (EXP_W > LZ_W) ? EXP_W : LZ_W;

    state_t             r_state, w_next;
    logic [2:0]         r_k;
    logic [W-1:0]       r_mant;
    logic [EXP_W-1:0]   r_exp;
    logic [LZ_W-1:0]    r_lz;
    logic [W-1:0]       r_o_mant;
    logic [EXP_W-1:0]   r_o_exp;
    logic [LZ_W-1:0]    r_o_lzc;
    logic               r_o_zero;
    logic               r_o_uflow;

    logic [7:0]         w_byte;
    logic [3:0]         w_blz;
    logic [LZ_W-1:0]    w_lz;
    logic [CMP_W-1:0]   w_lz_ext;
    logic [CMP_W-1:0]   w_exp_ext;

    // Byte k counted from the MSB end of the latched mantissa.
    always_comb begin
        w_byte = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (r_k == 3'(b)) begin
                w_byte = r_mant[W-8-8*b +: 8];
            end
        end
    end

    // 8-bit leading-zero count; the highest set bit is visited last and wins.
    always_comb begin
        w_blz = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (w_byte[i]) begin
                w_blz = 4'(7 - i);
            end
        end
    end

    assign w_lz      = LZ_W'({r_k, 3'b000}) + LZ_W'(w_blz);
    assign w_lz_ext  = CMP_W'(r_lz);
    assign w_exp_ext = CMP_W'(r_exp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_byte != 8'h00)  w_next = S_SHIFT;
                else if (r_k == K_LAST) w_next = S_DONE;
            end
            S_SHIFT: w_next = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k       <= '0;
            r_mant    <= '0;
            r_exp     <= '0;
            r_lz      <= '0;
            r_o_mant  <= '0;
            r_o_exp   <= '0;
            r_o_lzc   <= '0;
            r_o_zero  <= 1'b0;
            r_o_uflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_mant <= i_mant;
                        r_exp  <= i_exp;
                        r_k    <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_byte != 8'h00) begin
                        r_lz <= w_lz;
                    end else if (r_k != K_LAST) begin
                        r_k <= r_k + 3'd1;
                    end else begin
                        r_o_mant  <= '0;
                        r_o_exp   <= '0;
                        r_o_lzc   <= LZ_W'(W);
                        r_o_zero  <= 1'b1;
                        r_o_uflow <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_o_mant <= r_mant << r_lz;
                    r_o_lzc  <= r_lz;
                    r_o_zero <= 1'b0;
                    if (w_lz_ext > w_exp_ext) begin
                        r_o_exp   <= '0;
                        r_o_uflow <= 1'b1;
                    end else begin
                        r_o_exp   <= EXP_W'(w_exp_ext - w_lz_ext);
                        r_o_uflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mant  = r_o_mant;
    assign o_exp   = r_o_exp;
    assign o_lzc   = r_o_lzc;
    assign o_zero  = r_o_zero;
    assign o_uflow = r_o_uflow;

endmodule

// File: tb/tb_fp_norm_seq.sv
// tb/tb_fp_norm_seq.sv - directed table-driven bench for fp_norm_seq
module tb_fp_norm_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [47:0] i_mant;
    logic [9:0]  i_exp;
    logic        o_valid;
    logic        i_ready;
    logic [47:0] o_mant;
    logic [9:0]  o_exp;
    logic [6:0]  o_lzc;
    logic        o_zero;
    logic        o_uflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_norm_seq #(.W(48), .EXP_W(10), .LZ_W(7)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mant  (i_mant),
        .i_exp   (i_exp),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_mant  (o_mant),
        .o_exp   (o_exp),
        .o_lzc   (o_lzc),
        .o_zero  (o_zero),
        .o_uflow (o_uflow)
    );

    typedef struct {
        logic [47:0] mant;
        logic [9:0]  exp;
        int          lat;
        logic [47:0] emant;
        logic [9:0]  eexp;
        logic [6:0]  elzc;
        logic        ezero;
        logic        euflow;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; the accept happens on the next edge.
    task automatic accept(input logic [47:0] m, input logic [9:0] e);
        i_valid = 1'b1;
        i_mant  = m;
        i_exp   = e;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, " o_valid"}, 64'(o_valid), 64'd1);
        chk({tag, " o_mant"},  64'(o_mant),  64'(v.emant));
        chk({tag, " o_exp"},   64'(o_exp),   64'(v.eexp));
        chk({tag, " o_lzc"},   64'(o_lzc),   64'(v.elzc));
        chk({tag, " o_zero"},  64'(o_zero),  64'(v.ezero));
        chk({tag, " o_uflow"}, 64'(o_uflow), 64'(v.euflow));
        chk({tag, " o_ready"}, 64'(o_ready), 64'd0);
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    initial begin
        int   n;
        int   seen;
        vec_t hv;

        vecs[0] = '{48'h8000_0000_0000, 10'd100, 2, 48'h8000_0000_0000, 10'd100, 7'd0,  1'b0, 1'b0};
        vecs[1] = '{48'h0000_0000_0001, 10'd200, 7, 48'h8000_0000_0000, 10'd153, 7'd47, 1'b0, 1'b0};
        vecs[2] = '{48'h0000_0000_0000, 10'd55,  6, 48'h0000_0000_0000, 10'd0,   7'd48, 1'b1, 1'b0};
        vecs[3] = '{48'h0000_0010_0000, 10'd5,   5, 48'h8000_0000_0000, 10'd0,   7'd27, 1'b0, 1'b1};
        vecs[4] = '{48'h0012_3456_789A, 10'd11,  3, 48'h91A2_B3C4_D000, 10'd0,   7'd11, 1'b0, 1'b0};
        vecs[5] = '{48'h0012_3456_789A, 10'd10,  3, 48'h91A2_B3C4_D000, 10'd0,   7'd11, 1'b0, 1'b1};
        vecs[6] = '{48'h0000_0000_0080, 10'd300, 7, 48'h8000_0000_0000, 10'd260, 7'd40, 1'b0, 1'b0};
        vecs[7] = '{48'h00FF_FFFF_FFFF, 10'd12,  3, 48'hFFFF_FFFF_FF00, 10'd4,   7'd8,  1'b0, 1'b0};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_mant  = '0;
        i_exp   = '0;
        #12;
        chk("reset o_ready", 64'(o_ready), 64'd1);
        chk("reset o_valid", 64'(o_valid), 64'd0);
        chk("reset o_mant",  64'(o_mant),  64'd0);
        chk("reset o_lzc",   64'(o_lzc),   64'd0);
        chk("reset o_zero",  64'(o_zero),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].mant, vecs[i].exp);
            wait_valid(n);
            chk($sformatf("vec%0d latency", i), 64'(n), 64'(vecs[i].lat));
            check_out(vecs[i], $sformatf("vec%0d", i));
            release_result();
            chk($sformatf("vec%0d idle o_ready", i), 64'(o_ready), 64'd1);
            chk($sformatf("vec%0d idle o_valid", i), 64'(o_valid), 64'd0);
        end

        // Result held for 10 cycles with stray i_valid pulses, then released.
        hv = vecs[1];
        accept(hv.mant, hv.exp);
        wait_valid(n);
        chk("hold latency", 64'(n), 64'(hv.lat));
        for (int c = 0; c < 10; c++) begin
            i_valid = c[0];
            i_mant  = 48'h0000_0000_00FF;
            i_exp   = 10'd1;
            @(posedge clk);
            #1;
            check_out(hv, $sformatf("hold c%0d", c));
        end
        i_valid = 1'b0;
        release_result();
        chk("hold release o_ready", 64'(o_ready), 64'd1);
        chk("hold release o_valid", 64'(o_valid), 64'd0);
        accept(vecs[7].mant, vecs[7].exp);
        wait_valid(n);
        chk("post-hold latency", 64'(n), 64'(vecs[7].lat));
        check_out(vecs[7], "post-hold");
        release_result();

        // Reset mid-scan at k=3 (first nonzero byte is k=4).
        accept(48'h0000_0000_0100, 10'd40);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset o_valid", 64'(o_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort o_mant",  64'(o_mant),  64'd0);
        chk("abort o_exp",   64'(o_exp),   64'd0);
        chk("abort o_lzc",   64'(o_lzc),   64'd0);
        chk("abort o_zero",  64'(o_zero),  64'd0);
        chk("abort o_uflow", 64'(o_uflow), 64'd0);
        chk("abort o_valid", 64'(o_valid), 64'd0);
        chk("abort o_ready", 64'(o_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        chk("abort no o_valid", 64'(seen), 64'd0);
        chk("abort idle o_ready", 64'(o_ready), 64'd1);

        // First accept on the first rising edge after reset release.
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_mant  = vecs[6].mant;
        i_exp   = vecs[6].exp;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("first-edge accept o_ready", 64'(o_ready), 64'd0);
        wait_valid(n);
        chk("first-edge latency", 64'(n), 64'(vecs[6].lat));
        check_out(vecs[6], "first-edge");
        release_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
